// File: rtl/sum_accumulator.sv
// Accumulates NUM_SAMPLES unsigned 16-bit samples through an external adder and
// presents the wrapped sum with a sticky carry-out flag behind a valid/ready handshake.
module sum_accumulator #(
   parameter int unsigned NUM_SAMPLES = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic [15:0] in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [15:0] add_a,
   output logic [15:0] add_b,
   output logic        add_cin,
   input  logic [15:0] add_sum,
   input  logic        add_overflow,
   output logic [15:0] result,
   output logic        result_overflow,
   output logic        out_valid,
   input  logic        out_ready
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam logic [7:0] LAST_CNT = 8'(NUM_SAMPLES - 1);

   state_t      state_q;
   state_t      state_d;
   logic [15:0] acc_q;
   logic [15:0] acc_d;
   logic [7:0]  count_q;
   logic [7:0]  count_d;
   logic        ovf_q;
   logic        ovf_d;

   logic        in_ready_s;
   logic        out_valid_s;
   logic        accept_s;
   logic        handoff_s;

   assign in_ready_s  = (state_q != ST_DONE);
   assign out_valid_s = (state_q == ST_DONE);
   assign accept_s    = in_valid & in_ready_s;
   assign handoff_s   = out_valid_s & out_ready;

   assign add_a           = acc_q;
   assign add_b           = in_data;
   assign add_cin         = 1'b0;
   assign in_ready        = in_ready_s;
   assign out_valid       = out_valid_s;
   assign result          = acc_q;
   assign result_overflow = ovf_q;

   // Next-state logic: clear outranks both sample acceptance and result handoff
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      if (clear) begin
         state_d = ST_IDLE;
         acc_d   = 16'd0;
         count_d = 8'd0;
         ovf_d   = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept_s) begin
                  state_d = ST_ACCUM;
                  acc_d   = add_sum;
                  count_d = count_q + 8'd1;
                  ovf_d   = ovf_q | add_overflow;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_ACCUM: begin
               if (accept_s) begin
                  acc_d   = add_sum;
                  count_d = count_q + 8'd1;
                  ovf_d   = ovf_q | add_overflow;
                  if (count_q == LAST_CNT) begin
                     state_d = ST_DONE;
                  end else begin
                     state_d = ST_ACCUM;
                  end
               end else begin
                  state_d = ST_ACCUM;
               end
            end
            ST_DONE: begin
               if (handoff_s) begin
                  state_d = ST_IDLE;
                  acc_d   = 16'd0;
                  count_d = 8'd0;
                  ovf_d   = 1'b0;
               end else begin
                  state_d = ST_DONE;
               end
            end
            default: begin
               state_d = ST_IDLE;
               acc_d   = 16'd0;
               count_d = 8'd0;
               ovf_d   = 1'b0;
            end
         endcase
      end
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         acc_q   <= 16'd0;
         count_q <= 8'd0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed self-checking bench for sum_accumulator (NUM_SAMPLES = 4) with a
// behavioural 16-bit adder on the add_* link.
module tb_sum_accumulator;

   logic        clk;
   logic        reset;
   logic        clear;
   logic [15:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] add_a;
   logic [15:0] add_b;
   logic        add_cin;
   logic [15:0] add_sum;
   logic        add_overflow;
   logic [15:0] result;
   logic        result_overflow;
   logic        out_valid;
   logic        out_ready;

   int          checks;
   int          failures;
   logic [15:0] m_acc;
   logic        m_ovf;

   sum_accumulator #(.NUM_SAMPLES(4)) dut (
      .clk             (clk),
      .reset           (reset),
      .clear           (clear),
      .in_data         (in_data),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .add_a           (add_a),
      .add_b           (add_b),
      .add_cin         (add_cin),
      .add_sum         (add_sum),
      .add_overflow    (add_overflow),
      .result          (result),
      .result_overflow (result_overflow),
      .out_valid       (out_valid),
      .out_ready       (out_ready)
   );

   assign {add_overflow, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Offer one sample; optional idle gap cycles afterwards with acc-stability checks
   task automatic push(input logic [15:0] d, input int gap);
      logic [16:0] t;
      @(negedge clk);
      check_val("add_a_tracks_acc", {16'd0, add_a}, {16'd0, m_acc});
      check_val("add_cin_zero", {31'd0, add_cin}, 32'd0);
      in_valid = 1'b1;
      in_data  = d;
      t = {1'b0, m_acc} + {1'b0, d};
      m_acc = t[15:0];
      m_ovf = m_ovf | t[16];
      for (int i = 0; i < gap; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
         in_data  = 16'hDEAD;
         check_val("gap_acc_stable", {16'd0, add_a}, {16'd0, m_acc});
         check_val("gap_no_done", {31'd0, out_valid}, 32'd0);
      end
   endtask

   task automatic expect_done(input string tag, input logic [15:0] exp_res, input logic exp_ovf);
      @(negedge clk);
      in_valid = 1'b0;
      check_val({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
      check_val({tag, "_result"}, {16'd0, result}, {16'd0, exp_res});
      check_val({tag, "_ovf"}, {31'd0, result_overflow}, {31'd0, exp_ovf});
      check_val({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
   endtask

   task automatic expect_idle(input string tag);
      @(negedge clk);
      check_val({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
      check_val({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
      check_val({tag, "_result"}, {16'd0, result}, 32'd0);
      check_val({tag, "_ovf"}, {31'd0, result_overflow}, 32'd0);
      m_acc = 16'd0;
      m_ovf = 1'b0;
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      m_acc     = 16'd0;
      m_ovf     = 1'b0;
      reset     = 1'b1;
      clear     = 1'b0;
      in_data   = 16'd0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check_val("rst_result", {16'd0, result}, 32'd0);
      check_val("rst_ovf", {31'd0, result_overflow}, 32'd0);
      check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
      reset = 1'b0;

      // basic back-to-back: 1+2+3+4 = 0x000A, out_valid one cycle only
      push(16'h0001, 0);
      push(16'h0002, 0);
      push(16'h0003, 0);
      push(16'h0004, 0);
      expect_done("basic", 16'h000A, 1'b0);
      expect_idle("basic_after");

      // wrap: FFFF+2 = 0x0001 with carry; sticky flag cleared for next batch
      push(16'hFFFF, 0);
      push(16'h0002, 0);
      push(16'h0000, 0);
      push(16'h0000, 0);
      expect_done("wrap", 16'h0001, 1'b1);
      expect_idle("wrap_after");
      push(16'h0001, 0);
      push(16'h0001, 0);
      push(16'h0001, 0);
      push(16'h0001, 0);
      expect_done("wrap_next", 16'h0004, 1'b0);
      expect_idle("wrap_next_after");

      // backpressure: 7+8+9+10 = 0x0022 held for 5 cycles, in_valid ignored
      out_ready = 1'b0;
      push(16'h0007, 0);
      push(16'h0008, 0);
      push(16'h0009, 0);
      push(16'h000A, 0);
      expect_done("bp", 16'h0022, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_val("bp_hold_valid", {31'd0, out_valid}, 32'd1);
         check_val("bp_hold_result", {16'd0, result}, 32'h0022);
         check_val("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
         in_valid = ((i % 2) == 0) ? 1'b1 : 1'b0;
         in_data  = 16'hFFFF;
      end
      @(negedge clk);
      check_val("bp_still_valid", {31'd0, out_valid}, 32'd1);
      check_val("bp_still_result", {16'd0, result}, 32'h0022);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      expect_idle("bp_release");

      // gaps: 4 x 0x1000 separated by 3 idle cycles
      push(16'h1000, 3);
      push(16'h1000, 3);
      push(16'h1000, 3);
      push(16'h1000, 0);
      expect_done("gaps", 16'h4000, 1'b0);
      expect_idle("gaps_after");

      // clear mid-accumulation, with a concurrent in_valid that must lose
      push(16'h0005, 0);
      push(16'h0005, 0);
      @(negedge clk);
      clear    = 1'b1;
      in_valid = 1'b1;
      in_data  = 16'h0005;
      @(negedge clk);
      clear    = 1'b0;
      in_valid = 1'b0;
      check_val("clr_acc", {16'd0, add_a}, 32'd0);
      check_val("clr_out_valid", {31'd0, out_valid}, 32'd0);
      check_val("clr_in_ready", {31'd0, in_ready}, 32'd1);
      m_acc = 16'd0;
      m_ovf = 1'b0;
      push(16'h0005, 0);
      push(16'h0005, 0);
      push(16'h0005, 0);
      push(16'h0005, 0);
      expect_done("clr_next", 16'h0014, 1'b0);
      expect_idle("clr_next_after");

      // reset mid-accumulation
      push(16'h0005, 0);
      push(16'h0005, 0);
      @(negedge clk);
      reset    = 1'b1;
      in_valid = 1'b1;
      in_data  = 16'h0005;
      @(negedge clk);
      reset    = 1'b0;
      in_valid = 1'b0;
      check_val("rstm_acc", {16'd0, add_a}, 32'd0);
      check_val("rstm_out_valid", {31'd0, out_valid}, 32'd0);
      check_val("rstm_in_ready", {31'd0, in_ready}, 32'd1);
      m_acc = 16'd0;
      m_ovf = 1'b0;
      push(16'h0005, 0);
      push(16'h0005, 0);
      push(16'h0005, 0);
      push(16'h0005, 0);
      expect_done("rstm_next", 16'h0014, 1'b0);
      expect_idle("rstm_next_after");

      // reset while holding a result in DONE
      out_ready = 1'b0;
      push(16'hFFFF, 0);
      push(16'h0001, 0);
      push(16'h0001, 0);
      push(16'h0001, 0);
      expect_done("rstd", 16'h0002, 1'b1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset     = 1'b0;
      out_ready = 1'b1;
      check_val("rstd_out_valid", {31'd0, out_valid}, 32'd0);
      check_val("rstd_result", {16'd0, result}, 32'd0);
      check_val("rstd_ovf", {31'd0, result_overflow}, 32'd0);
      check_val("rstd_in_ready", {31'd0, in_ready}, 32'd1);
      m_acc = 16'd0;
      m_ovf = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sum_accumulator.md
SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 The block SHALL have parameter NUM_SAMPLES, default 4, meaning samples summed per result (legal range 2..256).
REQ-002 The block SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port clear  input  1  synchronous abort of the current accumulation.
REQ-005 The block SHALL have port in_data  input  16  unsigned sample.
REQ-006 The block SHALL have port in_valid  input  1  in_data is valid.
REQ-007 The block SHALL have port in_ready  output  1  block accepts a sample this cycle.
REQ-008 The block SHALL have port add_a  output  16  operand A to the external 16-bit adder.
REQ-009 The block SHALL have port add_b  output  16  operand B to the external 16-bit adder.
REQ-010 The block SHALL have port add_cin  output  1  adder carry_in.
REQ-011 The block SHALL have port add_sum  input  16  adder sum output.
REQ-012 The block SHALL have port add_overflow  input  1  adder carry-out of the MSB.
REQ-013 The block SHALL have port result  output  16  final accumulated sum.
REQ-014 The block SHALL have port result_overflow  output  1  sticky overflow for this result.
REQ-015 The block SHALL have port out_valid  output  1  result and result_overflow are valid.
REQ-016 The block SHALL have port out_ready  input  1  downstream consumes the result.

Function
REQ-017 The block SHALL hold registers acc[15:0], count[7:0] and ovf_sticky, and SHALL implement a 3-state FSM: IDLE, ACCUM, DONE.
REQ-018 The block SHALL drive add_a = acc, add_b = in_data and add_cin = 0, all combinationally.
REQ-019 The block SHALL assert in_ready = 1 in IDLE and ACCUM and in_ready = 0 in DONE.
REQ-020 A sample is accepted when in_valid and in_ready are both 1 at a rising edge; on acceptance the block SHALL load acc <= add_sum, set count <= count+1, and set ovf_sticky <= ovf_sticky | add_overflow.
REQ-021 Sums SHALL be unsigned modulo 2^16; once a carry-out occurs, acc SHALL wrap and ovf_sticky SHALL remain 1 until the result is handed off.
REQ-022 FSM transitions SHALL be as follows.
  - IDLE -> ACCUM on the first accepted sample.
  - ACCUM -> DONE when a sample is accepted with count == NUM_SAMPLES-1.
  - DONE -> IDLE when out_valid & out_ready.
  - Otherwise the FSM SHALL hold its state.
REQ-023 The block SHALL assert out_valid only in DONE, with result = acc and result_overflow = ovf_sticky.
REQ-024 Latency SHALL be exactly 1 cycle: out_valid rises in the cycle after the edge that accepts the final sample.
REQ-025 In DONE, result, result_overflow and out_valid SHALL hold stable until out_ready = 1; in_valid SHALL be ignored there.
REQ-026 On handoff (out_valid & out_ready), acc, count and ovf_sticky SHALL clear to 0, and in_ready SHALL be 1 in the following cycle; no back-to-back accept is allowed in the handoff cycle.
REQ-027 While in_valid = 0, the block SHALL keep acc and count unchanged (gaps are allowed).
REQ-028 When clear = 1 at an edge, the block SHALL behave as reset for acc, count, ovf_sticky and state; clear SHALL take priority over acceptance and handoff in the same cycle.
REQ-029 An in_data of 0 SHALL count as a sample.

Reset
REQ-030 When reset = 1 at a rising edge, the block SHALL set state = IDLE and acc = 0, count = 0, ovf_sticky = 0.
REQ-031 While in reset, the block SHALL drive out_valid = 0, result = 0, result_overflow = 0 and in_ready = 1 (after the first reset edge).
REQ-032 reset SHALL override clear, acceptance and handoff, including mid-accumulation and while in DONE.

Verification
REQ-033 Basic accumulation: NUM_SAMPLES=4; stream 0x0001, 0x0002, 0x0003, 0x0004 back-to-back with out_ready = 1 -> out_valid for exactly 1 cycle, result = 0x000A, result_overflow = 0, one cycle after the 4th accept.
REQ-034 Wrap-around: stream 0xFFFF, 0x0002, 0x0000, 0x0000 -> result = 0x0001, result_overflow = 1; the next batch of 1, 1, 1, 1 -> result = 0x0004, result_overflow = 0.
REQ-035 Backpressure: hold out_ready = 0 for 5 cycles after out_valid -> result held stable, in_ready = 0, extra in_valid pulses ignored; raise out_ready -> IDLE next cycle, in_ready = 1.
REQ-036 Gaps: 4 samples of 0x1000 separated by 3 idle cycles each -> result = 0x4000, with no spurious acc or count changes during gaps.
REQ-037 Mid-operation abort: accept 2 samples, then pulse clear (and separately, reset) -> acc = 0, count = 0, IDLE; the next 4 samples of 0x0005 -> result = 0x0014.
REQ-038 Adder link: bench connects an external adder to add_a/add_b/add_cin/add_sum/add_overflow -> add_cin is constant 0, and add_a tracks acc every cycle.
